// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture FSM states and queue sizing defaults.
package la_pkg;

    localparam int unsigned ENTRIES_DEF = 384;
    localparam int unsigned LOG2_DEF    = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } capture_state_t;

endpackage

// File: rtl/capture_ctrl.sv
// Capture sequencer: drives the shared RAM-queue write port, arms on enough pre-trigger
// history, counts post-trigger samples and pulses set_capture_done when the capture is complete.
module capture_ctrl
    import la_pkg::*;
#(
    parameter int unsigned ENTRIES = ENTRIES_DEF,
    parameter int unsigned LOG2    = LOG2_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wrt_smpl,
    input  logic            run,
    input  logic            capture_done,
    input  logic            triggered,
    input  logic [LOG2-1:0] trig_pos,
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic            armed,
    output logic            set_capture_done
);

    localparam int unsigned CW = LOG2 + 1;
    localparam int unsigned SW = LOG2 + 2;

    capture_state_t r_state;
    capture_state_t w_next;

    logic [CW-1:0]   r_smpl_cnt;
    logic [LOG2-1:0] r_post_cnt;
    logic [LOG2-1:0] r_waddr;
    logic            r_scd;

    logic [LOG2-1:0] w_tp;
    logic [LOG2-1:0] w_post_inc;
    logic [SW-1:0]   w_arm_sum;
    logic            w_start;

    // Post-trigger count can never exceed the queue, otherwise the trigger sample is overwritten.
    assign w_tp       = (trig_pos > LOG2'(ENTRIES - 1)) ? LOG2'(ENTRIES - 1) : trig_pos;
    assign w_arm_sum  = SW'(r_smpl_cnt) + SW'(w_tp);
    assign w_post_inc = r_post_cnt + LOG2'(1);
    assign w_start    = (r_state == IDLE) && (w_next == PRE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and combinational outputs
    always_comb begin
        w_next = r_state;
        we     = 1'b0;
        armed  = 1'b0;
        case (r_state)
            IDLE: begin
                if (run && !capture_done) begin
                    w_next = PRE;
                end
            end
            PRE: begin
                we    = wrt_smpl;
                armed = (w_arm_sum >= SW'(ENTRIES));
                if (!run) begin
                    w_next = IDLE;
                end else if (triggered && armed) begin
                    w_next = (w_tp == '0) ? DONE : POST;
                end
            end
            POST: begin
                we = wrt_smpl;
                if (!run) begin
                    w_next = IDLE;
                end else if (wrt_smpl && (w_post_inc == w_tp)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (!capture_done) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Address, sample counters and the done pulse; waddr wraps at ENTRIES-1, not a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_smpl_cnt <= '0;
            r_post_cnt <= '0;
            r_waddr    <= '0;
            r_scd      <= 1'b0;
        end else begin
            r_scd <= (w_next == DONE) && (r_state != DONE);
            if (w_start) begin
                r_smpl_cnt <= '0;
                r_post_cnt <= '0;
                r_waddr    <= '0;
            end else if (we) begin
                r_waddr <= (r_waddr == LOG2'(ENTRIES - 1)) ? '0 : r_waddr + LOG2'(1);
                if ((r_state == PRE) && (r_smpl_cnt != CW'(ENTRIES))) begin
                    r_smpl_cnt <= r_smpl_cnt + CW'(1);
                end
                if (r_state == POST) begin
                    r_post_cnt <= w_post_inc;
                end
            end
        end
    end

    assign waddr            = r_waddr;
    assign set_capture_done = r_scd;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: write addresses are scoreboarded, arming/done checked inline.
module tb_capture_ctrl;
    import la_pkg::*;

    localparam int unsigned N    = ENTRIES_DEF;
    localparam int unsigned LOG2 = LOG2_DEF;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wrt_smpl;
    logic            run;
    logic            capture_done;
    logic            triggered;
    logic [LOG2-1:0] trig_pos;
    logic            we;
    logic [LOG2-1:0] waddr;
    logic            armed;
    logic            set_capture_done;

    int n_tests  = 0;
    int n_fail   = 0;
    int scd_seen = 0;
    int mon_exp;
    int exp_q[$];

    always #5 clk = ~clk;

    capture_ctrl #(.ENTRIES(N), .LOG2(LOG2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wrt_smpl         (wrt_smpl),
        .run              (run),
        .capture_done     (capture_done),
        .triggered        (triggered),
        .trig_pos         (trig_pos),
        .we               (we),
        .waddr            (waddr),
        .armed            (armed),
        .set_capture_done (set_capture_done)
    );

    // Every RAM write is matched against the next expected address.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: write at waddr=%0d, none expected", waddr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (waddr !== LOG2'(mon_exp)) begin
                    n_fail++;
                    $display("FAIL wr_addr: got %0d, expected %0d", waddr, mon_exp);
                end
            end
        end
        if (set_capture_done === 1'b1) scd_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; capture_done = 1'b0; wrt_smpl = 1'b0;
        triggered = 1'b0; trig_pos = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
        scd_seen = 0;
    endtask

    task automatic push_writes(input int first, input int count);
        for (int k = 0; k < count; k++) exp_q.push_back((first + k) % N);
    endtask

    task automatic test_reset();
        exp_q.delete();
        rst_n = 1'b0; run = 1'b1; capture_done = 1'b0; wrt_smpl = 1'b1;
        triggered = 1'b1; trig_pos = LOG2'(10);
        tick();
        for (int i = 0; i < 3; i++) begin
            #2;
            n_tests++;
            if ({we, armed, set_capture_done} !== 3'b000 || waddr !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: we/armed/scd=%b%b%b waddr=%0d, expected 000 and 0",
                         we, armed, set_capture_done, waddr);
            end
            tick();
        end
        rst_n = 1'b1;
        #2;
        n_tests++;
        if (we !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_we: got %b, expected 0", we);
        end
        exp_q.push_back(0);
        tick(); #2;
        n_tests++;
        if (we !== 1'b1 || waddr !== '0) begin
            n_fail++; $display("FAIL reset_pre_entry: we=%b waddr=%0d, expected 1 and 0", we, waddr);
        end
        tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL reset_queue: %0d writes missing, expected 0", exp_q.size());
        end
    endtask

    // Runs a write-every-cycle capture and checks arming, the done pulse and the final address.
    task automatic test_trig_held();
        do_reset();
        trig_pos = LOG2'(10); triggered = 1'b1; wrt_smpl = 1'b1; run = 1'b1;
        push_writes(0, 385);
        tick();
        for (int c = 0; c < 385; c++) begin
            #2;
            n_tests++;
            if (armed !== (c == 374)) begin
                n_fail++; $display("FAIL held_armed c=%0d: got %b, expected %b", c, armed, (c == 374));
            end
            tick();
        end
        #2;
        n_tests++;
        if (we !== 1'b0 || set_capture_done !== 1'b1 || waddr !== LOG2'(1)) begin
            n_fail++;
            $display("FAIL held_done: we=%b scd=%b waddr=%0d, expected 0 1 1", we, set_capture_done, waddr);
        end
        capture_done = 1'b1;
        tick(); #2;
        n_tests++;
        if (set_capture_done !== 1'b0 || scd_seen != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL held_pulse: scd=%b pulses=%0d left=%0d, expected 0 1 0",
                     set_capture_done, scd_seen, exp_q.size());
        end
    endtask

    task automatic test_trig_pulse();
        do_reset();
        trig_pos = LOG2'(10); wrt_smpl = 1'b1; run = 1'b1;
        push_writes(0, 410);
        tick();
        for (int c = 0; c < 410; c++) begin
            triggered = (c == 99) || (c == 399);
            #2;
            n_tests++;
            if (armed !== (c >= 374 && c <= 399)) begin
                n_fail++; $display("FAIL pulse_armed c=%0d: got %b, expected %b", c, armed, (c >= 374 && c <= 399));
            end
            tick();
        end
        triggered = 1'b0;
        #2;
        n_tests++;
        if (we !== 1'b0 || set_capture_done !== 1'b1 || waddr !== LOG2'(26)) begin
            n_fail++;
            $display("FAIL pulse_done: we=%b scd=%b waddr=%0d, expected 0 1 26", we, set_capture_done, waddr);
        end
        capture_done = 1'b1;
        tick(); #2;
        n_tests++;
        if (scd_seen != 1 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL pulse_count: pulses=%0d left=%0d, expected 1 0", scd_seen, exp_q.size());
        end
    endtask

    task automatic test_tp_zero();
        do_reset();
        trig_pos = '0; triggered = 1'b1; wrt_smpl = 1'b1; run = 1'b1;
        push_writes(0, 385);
        tick();
        for (int c = 0; c < 385; c++) begin
            #2;
            n_tests++;
            if (armed !== (c == 384)) begin
                n_fail++; $display("FAIL tp0_armed c=%0d: got %b, expected %b", c, armed, (c == 384));
            end
            tick();
        end
        #2;
        n_tests++;
        if (we !== 1'b0 || set_capture_done !== 1'b1 || waddr !== LOG2'(1)) begin
            n_fail++;
            $display("FAIL tp0_done: we=%b scd=%b waddr=%0d, expected 0 1 1", we, set_capture_done, waddr);
        end
        capture_done = 1'b1;
        tick(); #2;
        n_tests++;
        if (we !== 1'b0 || scd_seen != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL tp0_after: we=%b pulses=%0d left=%0d, expected 0 1 0", we, scd_seen, exp_q.size());
        end
    endtask

    task automatic test_tp_clamp();
        do_reset();
        trig_pos = LOG2'(500); triggered = 1'b1; wrt_smpl = 1'b1; run = 1'b1;
        push_writes(0, 385);
        tick();
        for (int c = 0; c < 385; c++) begin
            #2;
            n_tests++;
            if (armed !== (c == 1)) begin
                n_fail++; $display("FAIL clamp_armed c=%0d: got %b, expected %b", c, armed, (c == 1));
            end
            tick();
        end
        #2;
        n_tests++;
        if (we !== 1'b0 || set_capture_done !== 1'b1 || waddr !== LOG2'(1)) begin
            n_fail++;
            $display("FAIL clamp_done: we=%b scd=%b waddr=%0d, expected 0 1 1", we, set_capture_done, waddr);
        end
        capture_done = 1'b1;
        tick(); #2;
        n_tests++;
        if (scd_seen != 1 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL clamp_count: pulses=%0d left=%0d, expected 1 0", scd_seen, exp_q.size());
        end
    endtask

    task automatic test_abort();
        do_reset();
        trig_pos = LOG2'(10); triggered = 1'b1; wrt_smpl = 1'b1; run = 1'b1;
        push_writes(0, 380);
        tick();
        for (int c = 0; c < 380; c++) tick();
        wrt_smpl = 1'b0; run = 1'b0;
        tick();
        wrt_smpl = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_tests++;
            if (we !== 1'b0 || set_capture_done !== 1'b0 || waddr !== LOG2'(380)) begin
                n_fail++;
                $display("FAIL abort_hold c=%0d: we=%b scd=%b waddr=%0d, expected 0 0 380",
                         c, we, set_capture_done, waddr);
            end
            tick();
        end
        n_tests++;
        if (scd_seen != 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL abort_count: pulses=%0d left=%0d, expected 0 0", scd_seen, exp_q.size());
        end
    endtask

    task automatic test_rearm();
        do_reset();
        trig_pos = LOG2'(500); triggered = 1'b1; wrt_smpl = 1'b1; run = 1'b1;
        push_writes(0, 385);
        tick();
        for (int c = 0; c < 385; c++) tick();
        #2;
        n_tests++;
        if (set_capture_done !== 1'b1) begin
            n_fail++; $display("FAIL rearm_pulse: got %b, expected 1", set_capture_done);
        end
        capture_done = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            #2;
            n_tests++;
            if (we !== 1'b0 || set_capture_done !== 1'b0 || waddr !== LOG2'(1)) begin
                n_fail++;
                $display("FAIL rearm_done_hold c=%0d: we=%b scd=%b waddr=%0d, expected 0 0 1",
                         c, we, set_capture_done, waddr);
            end
            tick();
        end
        capture_done = 1'b0;
        tick(); #2;
        n_tests++;
        if (we !== 1'b0 || waddr !== LOG2'(1)) begin
            n_fail++; $display("FAIL rearm_idle: we=%b waddr=%0d, expected 0 1", we, waddr);
        end
        exp_q.push_back(0);
        tick(); #2;
        n_tests++;
        if (we !== 1'b1 || waddr !== '0) begin
            n_fail++; $display("FAIL rearm_pre: we=%b waddr=%0d, expected 1 0", we, waddr);
        end
        tick();
        wrt_smpl = 1'b0; run = 1'b0;
        tick();
        n_tests++;
        if (scd_seen != 1 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rearm_count: pulses=%0d left=%0d, expected 1 0", scd_seen, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        trig_pos = LOG2'(10); triggered = 1'b0; wrt_smpl = 1'b1; run = 1'b1;
        push_writes(0, 20);
        tick();
        for (int c = 0; c < 20; c++) tick();
        rst_n = 1'b0; wrt_smpl = 1'b0;
        tick();
        wrt_smpl = 1'b1;
        #2;
        n_tests++;
        if (we !== 1'b0 || armed !== 1'b0 || waddr !== '0 || set_capture_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: we=%b armed=%b waddr=%0d scd=%b, expected 0 0 0 0",
                     we, armed, waddr, set_capture_done);
        end
        tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL midrst_queue: %0d writes missing, expected 0", exp_q.size());
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_trig_held();
        test_trig_pulse();
        test_tp_zero();
        test_tp_clamp();
        test_abort();
        test_rearm();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Capture sequencer for the logic analyzer. Drives the shared write port of the five channel RAM queues and decides how many samples are taken before and after the trigger. Reads `run` and `capture_done` from the `TrigCfg` register and `trig_pos` from the command/config block. Returns `set_capture_done` and leaves `waddr` pointing at the oldest sample, so a host dump can start its read address at `waddr`.

## Interface
- `ENTRIES`, 384: queue depth. 384 for simulation, 12288 for the DE-0.
- `LOG2`, 9: address width, equal to ceil(log2(ENTRIES)).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low. One clock; all flops use synchronous active-low reset.
- `wrt_smpl`  in  1  one-cycle strobe from clk_rst_smpl marking a decimated sample to store.
- `run`  in  1  `TrigCfg[4]`, capture enable.
- `capture_done`  in  1  `TrigCfg[5]`.
- `triggered`  in  1  trigger-logic output; honoured only while `armed`=1.
- `trig_pos`  in  LOG2  number of samples to store after the trigger sample.
- `we`  out  1  write enable to all RAM queues.
- `waddr`  out  LOG2  write address to all queues.
- `armed`  out  1  enough pre-trigger samples are held; trigger is allowed.
- `set_capture_done`  out  1  one-cycle pulse that sets `TrigCfg[5]`.

## Operation
- States: IDLE, PRE, POST, DONE.
- IDLE
  - `run` && !`capture_done` -> PRE.
  - On that transition: `smpl_cnt`=0, `post_cnt`=0, `waddr`=0.
- PRE
  - `we` = `wrt_smpl`.
  - On each write: `waddr` increments; `smpl_cnt` (LOG2+1 bits) increments, saturating at ENTRIES.
  - `tp` = min(`trig_pos`, ENTRIES-1).
  - `armed` = (`smpl_cnt` + `tp` >= ENTRIES). The sum is computed at LOG2+2 bits.
  - `triggered` && `armed` -> POST, or -> DONE if `tp`==0. The sample written in the same cycle, if any, is the trigger sample.
- POST
  - `we` = `wrt_smpl`.
  - On each write: `post_cnt`++ and `waddr`++.
  - The write that makes `post_cnt`==`tp` -> DONE.
  - `triggered` is ignored.
- DONE
  - `we`=0.
  - Remains here until `capture_done`==0, then -> IDLE.
  - `capture_done` clearing while `run` is still 1 therefore re-arms via IDLE one cycle later.
- `waddr` wrap: ENTRIES-1 -> 0, so it is not a power-of-2 wrap.
- Abort: `run`=0 in PRE or POST -> IDLE. No `set_capture_done`. `waddr` is held.

## Timing
- Reset values: state=IDLE; `we`=0; `waddr`=0; `armed`=0; `set_capture_done`=0; both counters 0.
- `we` is combinational from state and `wrt_smpl`, valid the same cycle as `wrt_smpl`.
- `waddr` presents the current write address and advances on the clock edge after a write.
- `armed` is combinational from state, `smpl_cnt` and `tp`. It is 0 outside PRE.
- `set_capture_done` is registered: high for exactly the first cycle in DONE, i.e. one cycle after the final write or after the trigger cycle when `tp`==0.
- Simultaneous `wrt_smpl` and `triggered` in PRE: the sample is written and counted in `smpl_cnt`. `armed` is evaluated on the pre-edge `smpl_cnt`.
- `triggered` while `armed`=0: ignored, no state change.
- `rst_n` low mid-capture: all state returns to reset values on the next edge, regardless of `run`.
- Latency from last write to `TrigCfg[5]` set: 2 clocks (pulse, then register update).

## Structure
- Shared package `la_pkg`: the `capture_state_t` enum (IDLE, PRE, POST, DONE). The same package holds the `ENTRIES`/`LOG2` defaults used by this block and the config block.
- Single module. No sub-module; the address and sample counters are inline flops.
- Wrap logic uses a compare against ENTRIES-1, not a modulo operator.

## Test plan
- Reset with `run`=1 held: all outputs 0 and state IDLE while `rst_n`=0. PRE is entered one cycle after `rst_n`=1.
- `trig_pos`=10, `wrt_smpl` every cycle, `triggered` held 1:
  - `armed` rises once `smpl_cnt` reaches 374.
  - Trigger taken with write #375.
  - 10 more writes, then `set_capture_done` pulses once.
  - Final `waddr` = 385 mod 384 = 1.
- `trig_pos`=10, `triggered` pulsed with write #400: `set_capture_done` follows write #410, final `waddr`=26. A trigger pulse at write #100 is ignored.
- `trig_pos`=0: the trigger cycle goes straight to DONE, `set_capture_done` pulses the next cycle, and `we` is never asserted in POST.
- `trig_pos`=500 (>=ENTRIES): clamped to 383. `armed` after 1 sample; 383 post writes.
- Abort and re-arm:
  - `run` dropped in POST: IDLE with no pulse and `waddr` held.
  - In DONE, clearing `capture_done` with `run`=1 returns to IDLE, then PRE next cycle with `waddr`=0.
